// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand forwarding / load-use hazard unit.
package fwd_pkg;

    // Select encoding for the EX-stage operand mux; 2'd3 is reserved and muxes as HELD.
    typedef enum logic [1:0] {
        FWD_HELD  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fwd_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

    // The stall down-counter needs at least one bit even when LOAD_STALL = 1.
    function automatic int cnt_width(input int load_stall);
        return (clog2(load_stall) < 1) ? 1 : clog2(load_stall);
    endfunction

endpackage

// File: rtl/fwd_src_lane.sv
// One source-operand lane: ID-stage forwarding decision, registered select/held
// operand, and the EX-stage operand mux.
module fwd_src_lane
    import fwd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int ZERO_REG_EN = 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] src_reg,
    input  logic [DATA_W-1:0] src_value,
    input  logic [REG_AW-1:0] idex_regd,
    input  logic              idex_regwrite,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] exmem_regd,
    input  logic              exmem_regwrite,
    input  logic [DATA_W-1:0] exmem_value,
    input  logic [REG_AW-1:0] memwb_regd,
    input  logic              memwb_regwrite,
    input  logic [DATA_W-1:0] memwb_value,
    input  logic              stall,
    output logic              hazard,
    output logic [DATA_W-1:0] fwd_out,
    output logic [1:0]        sel
);

    logic              src_zero;
    logic              idex_hit;
    logic              exmem_hit;
    logic              memwb_hit;
    fwd_sel_e          sel_next;
    fwd_sel_e          sel_q;
    logic [DATA_W-1:0] held_next;
    logic [DATA_W-1:0] held_q;

    assign src_zero  = (ZERO_REG_EN != 0) && (src_reg == '0);
    assign idex_hit  = idex_regwrite  && (idex_regd  == src_reg) && !src_zero;
    assign exmem_hit = exmem_regwrite && (exmem_regd == src_reg) && !src_zero;
    assign memwb_hit = memwb_regwrite && (memwb_regd == src_reg) && !src_zero;

    // Newest producer wins; a WB result is captured now because it leaves the pipe next cycle.
    always_comb begin
        sel_next  = FWD_HELD;
        held_next = src_value;
        hazard    = 1'b0;
        if (id_valid) begin
            if (src_zero) begin
                held_next = '0;
            end else if (idex_hit && idex_memread) begin
                hazard    = 1'b1;
                held_next = '0;
            end else if (idex_hit) begin
                sel_next = FWD_EXMEM;
            end else if (exmem_hit) begin
                sel_next = FWD_MEMWB;
            end else if (memwb_hit) begin
                held_next = memwb_value;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sel_q  <= FWD_HELD;
            held_q <= '0;
        end else if (stall) begin
            sel_q  <= FWD_HELD;
            held_q <= '0;
        end else begin
            sel_q  <= sel_next;
            held_q <= held_next;
        end
    end

    always_comb begin
        case (sel_q)
            FWD_EXMEM: fwd_out = exmem_value;
            FWD_MEMWB: fwd_out = memwb_value;
            default:   fwd_out = held_q;
        endcase
    end

    assign sel = sel_q;

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding and load-use stall control for the 5-stage pipeline:
// per-lane decisions made in ID, registered into EX, plus the stall sequencer.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | normal issue; Stall follows the load-use hazard of any lane
//   ST_STALL | extra stall cycles of a multi-cycle load-use stall (cnt down)
module forward_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int NUM_SRC     = 2,
    parameter int LOAD_STALL  = 1,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic                      ID_Valid,
    input  logic [NUM_SRC*REG_AW-1:0] ID_SrcReg,
    input  logic [NUM_SRC*DATA_W-1:0] ID_SrcValue,
    input  logic [REG_AW-1:0]         IDEX_RegD,
    input  logic                      IDEX_RegWrite,
    input  logic                      IDEX_MemRead,
    input  logic [REG_AW-1:0]         EXMEM_RegD,
    input  logic                      EXMEM_RegWrite,
    input  logic [DATA_W-1:0]         EXMEM_RegD_Value,
    input  logic [REG_AW-1:0]         MEMWB_RegD,
    input  logic                      MEMWB_RegWrite,
    input  logic [DATA_W-1:0]         MEMWB_RegD_Value,
    output logic [NUM_SRC*DATA_W-1:0] Forward_Out,
    output logic [NUM_SRC*2-1:0]      Forward_Sel,
    output logic                      Stall,
    output logic                      Bubble
);

    localparam int CNT_W = cnt_width(LOAD_STALL);
    // The RUN-state cycle that detects the hazard is the first stall cycle.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LOAD_STALL > 1) ? LOAD_STALL - 2 : 0);

    logic [NUM_SRC-1:0] lane_hazard;
    logic               hazard_any;
    fwd_state_e         state;
    fwd_state_e         state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
        fwd_src_lane #(
            .DATA_W      (DATA_W),
            .REG_AW      (REG_AW),
            .ZERO_REG_EN (ZERO_REG_EN)
        ) u_lane (
            .CLOCK          (CLOCK),
            .RESET          (RESET),
            .id_valid       (ID_Valid),
            .src_reg        (ID_SrcReg[i*REG_AW +: REG_AW]),
            .src_value      (ID_SrcValue[i*DATA_W +: DATA_W]),
            .idex_regd      (IDEX_RegD),
            .idex_regwrite  (IDEX_RegWrite),
            .idex_memread   (IDEX_MemRead),
            .exmem_regd     (EXMEM_RegD),
            .exmem_regwrite (EXMEM_RegWrite),
            .exmem_value    (EXMEM_RegD_Value),
            .memwb_regd     (MEMWB_RegD),
            .memwb_regwrite (MEMWB_RegWrite),
            .memwb_value    (MEMWB_RegD_Value),
            .stall          (Stall),
            .hazard         (lane_hazard[i]),
            .fwd_out        (Forward_Out[i*DATA_W +: DATA_W]),
            .sel            (Forward_Sel[i*2 +: 2])
        );
    end

    assign hazard_any = |lane_hazard;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_RUN: begin
                if (hazard_any && (LOAD_STALL > 1)) begin
                    state_next = ST_STALL;
                    cnt_next   = CNT_INIT;
                end
            end
            ST_STALL: begin
                if (cnt == '0) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        Stall = 1'b0;
        if (!RESET) begin
            case (state)
                ST_RUN:   Stall = hazard_any;
                ST_STALL: Stall = 1'b1;
                default:  Stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            Bubble <= 1'b0;
        end else begin
            Bubble <= Stall;
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: vector table, directed stall/reset sequences
// and a randomized run against a rule-level reference model (LOAD_STALL 1 and 3).
module tb_forward_hazard_unit;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;

    logic                      CLOCK = 1'b0;
    logic                      RESET;
    logic                      ID_Valid;
    logic [NUM_SRC*REG_AW-1:0] ID_SrcReg;
    logic [NUM_SRC*DATA_W-1:0] ID_SrcValue;
    logic [REG_AW-1:0]         IDEX_RegD, EXMEM_RegD, MEMWB_RegD;
    logic                      IDEX_RegWrite, IDEX_MemRead, EXMEM_RegWrite, MEMWB_RegWrite;
    logic [DATA_W-1:0]         EXMEM_RegD_Value, MEMWB_RegD_Value;

    logic [NUM_SRC*DATA_W-1:0] out1, out3;
    logic [NUM_SRC*2-1:0]      sel1, sel3;
    logic                      stall1, stall3, bub1, bub3;

    always #5 CLOCK = ~CLOCK;

    forward_hazard_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
                          .LOAD_STALL(1), .ZERO_REG_EN(1)) u_ls1 (
        .CLOCK(CLOCK), .RESET(RESET), .ID_Valid(ID_Valid), .ID_SrcReg(ID_SrcReg),
        .ID_SrcValue(ID_SrcValue), .IDEX_RegD(IDEX_RegD), .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_MemRead(IDEX_MemRead), .EXMEM_RegD(EXMEM_RegD), .EXMEM_RegWrite(EXMEM_RegWrite),
        .EXMEM_RegD_Value(EXMEM_RegD_Value), .MEMWB_RegD(MEMWB_RegD),
        .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_RegD_Value(MEMWB_RegD_Value),
        .Forward_Out(out1), .Forward_Sel(sel1), .Stall(stall1), .Bubble(bub1));

    forward_hazard_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC),
                          .LOAD_STALL(3), .ZERO_REG_EN(1)) u_ls3 (
        .CLOCK(CLOCK), .RESET(RESET), .ID_Valid(ID_Valid), .ID_SrcReg(ID_SrcReg),
        .ID_SrcValue(ID_SrcValue), .IDEX_RegD(IDEX_RegD), .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_MemRead(IDEX_MemRead), .EXMEM_RegD(EXMEM_RegD), .EXMEM_RegWrite(EXMEM_RegWrite),
        .EXMEM_RegD_Value(EXMEM_RegD_Value), .MEMWB_RegD(MEMWB_RegD),
        .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_RegD_Value(MEMWB_RegD_Value),
        .Forward_Out(out3), .Forward_Sel(sel3), .Stall(stall3), .Bubble(bub3));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_src(input int lane, input int rn, input logic [31:0] val);
        ID_SrcReg[lane*REG_AW +: REG_AW]   = REG_AW'(rn);
        ID_SrcValue[lane*DATA_W +: DATA_W] = val;
    endtask

    task automatic clear_inputs();
        ID_Valid = 1'b0; ID_SrcReg = '0; ID_SrcValue = '0;
        IDEX_RegD = '0; IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0;
        EXMEM_RegD = '0; EXMEM_RegWrite = 1'b0; EXMEM_RegD_Value = '0;
        MEMWB_RegD = '0; MEMWB_RegWrite = 1'b0; MEMWB_RegD_Value = '0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        clear_inputs();
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    task automatic randomize_inputs();
        ID_Valid = ($urandom_range(0, 7) != 0);
        for (int l = 0; l < NUM_SRC; l++) set_src(l, $urandom_range(0, 7), $urandom);
        IDEX_RegD = REG_AW'($urandom_range(0, 7));
        IDEX_RegWrite = ($urandom_range(0, 3) != 0);
        IDEX_MemRead = ($urandom_range(0, 2) == 0);
        EXMEM_RegD = REG_AW'($urandom_range(0, 7));
        EXMEM_RegWrite = ($urandom_range(0, 3) != 0);
        EXMEM_RegD_Value = $urandom;
        MEMWB_RegD = REG_AW'($urandom_range(0, 7));
        MEMWB_RegWrite = ($urandom_range(0, 3) != 0);
        MEMWB_RegD_Value = $urandom;
    endtask

    // Reference decision: scan producers newest-first, the first writer of the source wins.
    function automatic void decide(input int lane, output bit haz, output int sel,
                                   output logic [31:0] held);
        int         src;
        int         rd[3];
        bit         we[3];
        src   = int'(ID_SrcReg[lane*REG_AW +: REG_AW]);
        rd[0] = int'(IDEX_RegD);  we[0] = IDEX_RegWrite;
        rd[1] = int'(EXMEM_RegD); we[1] = EXMEM_RegWrite;
        rd[2] = int'(MEMWB_RegD); we[2] = MEMWB_RegWrite;
        haz  = 1'b0;
        sel  = 0;
        held = ID_SrcValue[lane*DATA_W +: DATA_W];
        if (!ID_Valid) return;
        if (src == 0) begin
            held = '0;
            return;
        end
        for (int s = 0; s < 3; s++) begin
            if (we[s] && rd[s] == src) begin
                if (s == 0 && IDEX_MemRead) haz = 1'b1;
                else if (s < 2) sel = s + 1;
                else held = MEMWB_RegD_Value;
                return;
            end
        end
    endfunction

    typedef struct {
        int          valid, s0, s1;
        logic [31:0] v0, v1;
        int          xr, xw, xl, mr, mw;
        logic [31:0] mv;
        int          wr, ww;
        logic [31:0] wv;
        int          e_stall, e_sel0, e_sel1;
        logic [31:0] e_out0, e_out1;
    } vec_t;

    vec_t vecs[10];

    int          m_sel[2][NUM_SRC];
    logic [31:0] m_held[2][NUM_SRC];
    int          m_left[2];
    bit          m_bub[2];
    bit          d_haz[NUM_SRC];
    int          d_sel[NUM_SRC];
    logic [31:0] d_held[NUM_SRC];
    bit          hz_any;
    bit          e_stall;
    logic [31:0] e_out;
    logic [DATA_W*NUM_SRC-1:0] a_out;
    logic [NUM_SRC*2-1:0]      a_sel;
    logic                      a_stall, a_bub;

    initial begin
        //        vld s0  s1  v0        v1         xr xw xl mr mw mv         wr ww wv         st sel0 sel1 out0       out1
        vecs[0] = '{1, 8,  2,  32'h11,   32'h22,    8, 1, 0, 1, 1, 32'h1234,  4, 1, 32'h5555, 0, 1, 0, 32'h1234, 32'h22};
        vecs[1] = '{1, 5,  0,  32'h51,   32'h77,    5, 1, 0, 5, 1, 32'hAAAA,  5, 1, 32'hBBBB, 0, 1, 0, 32'hAAAA, 32'h0};
        vecs[2] = '{1, 0,  0,  32'h61,   32'h99,    0, 1, 0, 0, 1, 32'h1,     0, 1, 32'h2,    0, 0, 0, 32'h0,    32'h0};
        vecs[3] = '{1, 7,  6,  32'h71,   32'h72,    6, 1, 0, 7, 1, 32'hE0E0,  1, 1, 32'hF0F0, 0, 2, 1, 32'hF0F0, 32'hE0E0};
        vecs[4] = '{1, 3,  3,  32'h0,    32'h0,     2, 1, 0, 4, 1, 32'h1,     3, 1, 32'hBEEF, 0, 0, 0, 32'hBEEF, 32'hBEEF};
        vecs[5] = '{1, 4,  4,  32'h44,   32'h45,    4, 0, 1, 4, 0, 32'h1,     4, 0, 32'h2,    0, 0, 0, 32'h44,   32'h45};
        vecs[6] = '{1, 2,  9,  32'h21,   32'h91,    9, 1, 1, 2, 0, 32'h1,     2, 0, 32'h2,    1, 0, 0, 32'h0,    32'h0};
        vecs[7] = '{0, 9,  9,  32'h123,  32'h321,   9, 1, 1, 0, 0, 32'h0,     0, 0, 32'h0,    0, 0, 0, 32'h123,  32'h321};
        vecs[8] = '{1, 10, 11, 32'hA,    32'hB,     12, 1, 1, 13, 1, 32'h3,   14, 1, 32'h4,   0, 0, 0, 32'hA,    32'hB};
        vecs[9] = '{1, 12, 13, 32'hC,    32'hD,     12, 0, 1, 12, 1, 32'h3C3C, 13, 1, 32'h4D4D, 0, 2, 0, 32'h4D4D, 32'h4D4D};

        RESET = 1'b1;
        clear_inputs();

        // Reset with a live load-use hazard on the inputs.
        @(negedge CLOCK);
        randomize_inputs();
        ID_Valid = 1'b1;
        set_src(0, 6, 32'h66);
        IDEX_RegD = 5'd6; IDEX_RegWrite = 1'b1; IDEX_MemRead = 1'b1;
        #1;
        check("rst_stall_ls1", 32'(stall1), 0);
        check("rst_stall_ls3", 32'(stall3), 0);
        @(posedge CLOCK); #1;
        check("rst_out_ls1", out1, 0);
        check("rst_out_ls3", out3, 0);
        check("rst_sel_ls1", 32'(sel1), 0);
        check("rst_sel_ls3", 32'(sel3), 0);
        check("rst_bub_ls1", 32'(bub1), 0);
        check("rst_bub_ls3", 32'(bub3), 0);
        @(negedge CLOCK);
        clear_inputs();
        RESET = 1'b0;

        // Single-cycle vectors, checked on the LOAD_STALL = 1 instance.
        for (int v = 0; v < 10; v++) begin
            @(negedge CLOCK);
            ID_Valid = (vecs[v].valid != 0);
            set_src(0, vecs[v].s0, vecs[v].v0);
            set_src(1, vecs[v].s1, vecs[v].v1);
            IDEX_RegD = REG_AW'(vecs[v].xr); IDEX_RegWrite = (vecs[v].xw != 0);
            IDEX_MemRead = (vecs[v].xl != 0);
            EXMEM_RegD = REG_AW'(vecs[v].mr); EXMEM_RegWrite = (vecs[v].mw != 0);
            EXMEM_RegD_Value = vecs[v].mv;
            MEMWB_RegD = REG_AW'(vecs[v].wr); MEMWB_RegWrite = (vecs[v].ww != 0);
            MEMWB_RegD_Value = vecs[v].wv;
            #1;
            check($sformatf("vec%0d_stall", v), 32'(stall1), 32'(vecs[v].e_stall));
            @(posedge CLOCK); #1;
            check($sformatf("vec%0d_sel0", v), 32'(sel1[1:0]), 32'(vecs[v].e_sel0));
            check($sformatf("vec%0d_sel1", v), 32'(sel1[3:2]), 32'(vecs[v].e_sel1));
            check($sformatf("vec%0d_out0", v), out1[31:0], vecs[v].e_out0);
            check($sformatf("vec%0d_out1", v), out1[63:32], vecs[v].e_out1);
            check($sformatf("vec%0d_bubble", v), 32'(bub1), 32'(vecs[v].e_stall));
        end

        // Load-use with LOAD_STALL = 1: one stall, bubble, then MEM/WB forwarding.
        do_reset();
        @(negedge CLOCK);
        ID_Valid = 1'b1; set_src(0, 9, 32'h5); set_src(1, 1, 32'h6);
        IDEX_RegD = 5'd9; IDEX_RegWrite = 1'b1; IDEX_MemRead = 1'b1;
        #1 check("ls1_stall", 32'(stall1), 1);
        @(negedge CLOCK);
        IDEX_RegD = '0; IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0;
        EXMEM_RegD = 5'd9; EXMEM_RegWrite = 1'b1; EXMEM_RegD_Value = 32'h0BAD;
        #1;
        check("ls1_stall_done", 32'(stall1), 0);
        check("ls1_bubble", 32'(bub1), 1);
        check("ls1_bubble_sel", 32'(sel1[1:0]), 0);
        check("ls1_bubble_out", out1[31:0], 0);
        @(negedge CLOCK);
        ID_Valid = 1'b0; EXMEM_RegD = '0; EXMEM_RegWrite = 1'b0;
        MEMWB_RegD = 5'd9; MEMWB_RegWrite = 1'b1; MEMWB_RegD_Value = 32'hCAFE;
        #1;
        check("ls1_fwd_sel", 32'(sel1[1:0]), 2);
        check("ls1_fwd_out", out1[31:0], 32'hCAFE);
        check("ls1_bubble_clear", 32'(bub1), 0);

        // Load-use with LOAD_STALL = 3: exactly three stall cycles.
        do_reset();
        @(negedge CLOCK);
        ID_Valid = 1'b1; set_src(0, 9, 32'h5);
        IDEX_RegD = 5'd9; IDEX_RegWrite = 1'b1; IDEX_MemRead = 1'b1;
        #1 check("ls3_stall_c1", 32'(stall3), 1);
        @(negedge CLOCK);
        IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0;
        #1;
        check("ls3_stall_c2", 32'(stall3), 1);
        check("ls3_bubble_c2", 32'(bub3), 1);
        @(negedge CLOCK); #1;
        check("ls3_stall_c3", 32'(stall3), 1);
        @(negedge CLOCK); #1;
        check("ls3_stall_c4", 32'(stall3), 0);
        check("ls3_bubble_c4", 32'(bub3), 1);
        @(negedge CLOCK); #1;
        check("ls3_bubble_c5", 32'(bub3), 0);

        // Reset during the second stall cycle.
        @(negedge CLOCK);
        IDEX_RegWrite = 1'b1; IDEX_MemRead = 1'b1;
        #1 check("ls3_rst_c1", 32'(stall3), 1);
        @(negedge CLOCK);
        IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0;
        RESET = 1'b1;
        #1 check("ls3_rst_forced", 32'(stall3), 0);
        @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        check("ls3_rst_run", 32'(stall3), 0);
        check("ls3_rst_bubble", 32'(bub3), 0);
        @(negedge CLOCK); #1;
        check("ls3_rst_no_residual", 32'(stall3), 0);

        // MEM/WB value captured in ID survives the WB stage changing.
        do_reset();
        @(negedge CLOCK);
        ID_Valid = 1'b1; set_src(0, 3, 32'h0);
        MEMWB_RegD = 5'd3; MEMWB_RegWrite = 1'b1; MEMWB_RegD_Value = 32'hBEEF;
        @(negedge CLOCK);
        ID_Valid = 1'b0; MEMWB_RegD = 5'd7; MEMWB_RegD_Value = 32'h1111;
        #1;
        check("wb_cap_sel", 32'(sel1[1:0]), 0);
        check("wb_cap_out_ls1", out1[31:0], 32'hBEEF);
        check("wb_cap_out_ls3", out3[31:0], 32'hBEEF);

        // Randomized run against the reference model, both instances.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0;
            m_bub[k]  = 1'b0;
            for (int l = 0; l < NUM_SRC; l++) begin
                m_sel[k][l]  = 0;
                m_held[k][l] = '0;
            end
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge CLOCK);
            randomize_inputs();
            RESET = ($urandom_range(0, 31) == 0);
            #1;
            hz_any = 1'b0;
            for (int l = 0; l < NUM_SRC; l++) begin
                decide(l, d_haz[l], d_sel[l], d_held[l]);
                if (d_haz[l]) hz_any = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                a_stall = (k == 0) ? stall1 : stall3;
                a_bub   = (k == 0) ? bub1   : bub3;
                a_sel   = (k == 0) ? sel1   : sel3;
                a_out   = (k == 0) ? out1   : out3;
                e_stall = !RESET && ((m_left[k] > 0) || hz_any);
                check($sformatf("rnd%0d_k%0d_stall", c, k), 32'(a_stall), 32'(e_stall));
                check($sformatf("rnd%0d_k%0d_bubble", c, k), 32'(a_bub), 32'(m_bub[k]));
                for (int l = 0; l < NUM_SRC; l++) begin
                    if (m_sel[k][l] == 1)      e_out = EXMEM_RegD_Value;
                    else if (m_sel[k][l] == 2) e_out = MEMWB_RegD_Value;
                    else                       e_out = m_held[k][l];
                    check($sformatf("rnd%0d_k%0d_sel%0d", c, k, l), 32'(a_sel[l*2 +: 2]),
                          32'(m_sel[k][l]));
                    check($sformatf("rnd%0d_k%0d_out%0d", c, k, l), a_out[l*DATA_W +: DATA_W], e_out);
                end
                if (RESET) begin
                    m_left[k] = 0;
                    m_bub[k]  = 1'b0;
                    for (int l = 0; l < NUM_SRC; l++) begin
                        m_sel[k][l] = 0; m_held[k][l] = '0;
                    end
                end else begin
                    m_bub[k] = e_stall;
                    for (int l = 0; l < NUM_SRC; l++) begin
                        m_sel[k][l]  = e_stall ? 0  : d_sel[l];
                        m_held[k][l] = e_stall ? '0 : d_held[l];
                    end
                    if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
                    else if (hz_any)   m_left[k] = ((k == 0) ? 1 : 3) - 1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
